// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_port_arbiter_pkg: shared state encoding and default geometry for the SDRAM port arbiter
package sdram_port_arbiter_pkg;
  localparam int DEF_ADDR_W      = 22;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_MAX_VID_RUN = 4;
  typedef enum logic [2:0] {IDLE, REQ_V, REQ_U, XFER_V, XFER_U} arb_state_e;
endpackage

// File: rtl/sdram_port_arbiter_arb_burst_cnt.sv
// arb_burst_cnt: burst word counter with clear, increment and terminal-count flag
module arb_burst_cnt #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? '0 : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt = cnt_q;
  assign tc  = cnt_q == W'(N - 1);
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM app port between video reads and USB writes, one burst per grant
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int MAX_VID_RUN = DEF_MAX_VID_RUN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_rd_req,
  input  logic [ADDR_W-1:0] vid_rd_addr,
  output logic              vid_rd_gnt,
  output logic              vid_rd_valid,
  output logic [DATA_W-1:0] vid_rd_data,
  input  logic              usb_wr_req,
  input  logic [ADDR_W-1:0] usb_wr_addr,
  output logic              usb_wr_gnt,
  output logic              usb_wr_next,
  input  logic [DATA_W-1:0] usb_wr_data,
  output logic              app_rd_req,
  output logic              app_wr_req,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_ack,
  input  logic              app_wr_next,
  output logic [DATA_W-1:0] app_wr_data,
  input  logic              app_rd_valid,
  input  logic [DATA_W-1:0] app_rd_data,
  output logic              busy
);
  localparam int CW = $clog2(BURST_LEN);
  localparam int RW = $clog2(MAX_VID_RUN + 1);
  arb_state_e  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0] run_q, run_d;
  logic vgnt_q, vgnt_d, ugnt_q, ugnt_d;
  logic cnt_load, cnt_inc, cnt_tc, run_full;
  logic [CW-1:0] word_cnt;
  assign run_full = run_q == RW'(MAX_VID_RUN);
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    run_d    = run_q;
    vgnt_d   = 1'b0;
    ugnt_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!usb_wr_req) run_d = '0;
        if (usb_wr_req && (!vid_rd_req || run_full)) begin
          state_d = REQ_U;
          addr_d  = usb_wr_addr;
        end else if (vid_rd_req) begin
          state_d = REQ_V;
          addr_d  = vid_rd_addr;
        end
      end
      REQ_V: if (app_ack) begin
        state_d  = XFER_V;
        vgnt_d   = 1'b1;
        cnt_load = 1'b1;
        run_d    = (usb_wr_req && !run_full) ? run_q + RW'(1) : run_q;
      end
      REQ_U: if (app_ack) begin
        state_d  = XFER_U;
        ugnt_d   = 1'b1;
        cnt_load = 1'b1;
        run_d    = '0;
      end
      XFER_V: begin
        cnt_inc = app_rd_valid;
        if (app_rd_valid && cnt_tc) state_d = IDLE;
      end
      XFER_U: begin
        cnt_inc = app_wr_next;
        if (app_wr_next && cnt_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      run_q   <= '0;
      vgnt_q  <= 1'b0;
      ugnt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      run_q   <= run_d;
      vgnt_q  <= vgnt_d;
      ugnt_q  <= ugnt_d;
    end
  end
  arb_burst_cnt #(.N(BURST_LEN)) u_word_cnt (
    .clk  (clk),
    .reset(reset),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (word_cnt),
    .tc   (cnt_tc)
  );
  // Data paths are combinational pass-throughs, gated so stray strobes never leak out of a burst
  assign app_rd_req   = state_q == REQ_V;
  assign app_wr_req   = state_q == REQ_U;
  assign app_addr     = addr_q;
  assign vid_rd_gnt   = vgnt_q;
  assign usb_wr_gnt   = ugnt_q;
  assign vid_rd_valid = state_q == XFER_V && app_rd_valid;
  assign vid_rd_data  = state_q == XFER_V ? app_rd_data : '0;
  assign usb_wr_next  = state_q == XFER_U && app_wr_next;
  assign app_wr_data  = state_q == XFER_U ? usb_wr_data : '0;
  assign busy         = state_q != IDLE;
endmodule
